prefix_addsub_pipe: RTL and testbench

- Pipelined WIDTH-bit add/subtract unit built around a 4-level parallel-prefix carry network with spans 1, 2, 4 and 8.
- Generates bit-level p/g from its operands, resolves group G/P through the prefix levels, and then produces sum, carry-out and signed overflow.
- Sits in the datapath as the consumer of operand pairs. Valid/ready handshake on both sides, so it can be dropped between buffered stages.

---
 rtl/prefix_addsub_pipe.sv | 154 +++++++++++++++
 tb/tb_prefix_addsub_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_addsub_pipe.sv
// prefix_addsub_pipe
//   Pipelined WIDTH-bit add/subtract unit. Bit-level p/g feed a 4-level
//   parallel-prefix carry network with spans 1, 2, 4 and 8. The unit produces
//   the sum, carry-out and signed overflow. Three register stages are used:
//     S0 : prepared operands (p, g, effective carry-in, operand MSBs)
//     S1 : group G/P after prefix levels 1-2
//     S2 : prefix levels 3-4 plus sum logic; S2 drives the outputs
//   All stages advance together when the output is empty or being taken.
//
// Optional build macro:
//   PREFIX_ADDSUB_SATURATE_EN - when defined, an overflowing result is clamped
//   to the signed extreme in the direction of operand A's sign.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand-pair handshake
//   in_a, in_b        operands (WIDTH bits)
//   in_cin            carry-in (add) / borrow-in (subtract)
//   in_sub            0: A+B+cin, 1: A-B-cin
//   out_valid/out_ready result handshake
//   out_sum           result (WIDTH bits)
//   out_cout          carry-out; for subtract 1 means no borrow
//   out_ovf           signed two's-complement overflow
module prefix_addsub_pipe #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int STAGES = 3;
    localparam int LEVELS = 4;

    logic                advance;
    logic [STAGES-1:0]   vld_pipe;

    assign out_valid = vld_pipe[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    // Reset empties the pipe, so the input side is ready while reset is held.
    assign in_ready  = advance | rst;

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
    end

    // ---------------- operand preparation ----------------
    // Subtract is A + ~B + 1 - borrow_in, so the carry-in is inverted.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ^ in_cin;

    logic [WIDTH-1:0] s0_p, s0_g;
    logic             s0_cin, s0_amsb, s0_bmsb;

    always_ff @(posedge clk) begin
        if (advance) begin
            s0_p    <= in_a ^ b_eff;
            s0_g    <= in_a & b_eff;
            s0_cin  <= cin_eff;
            s0_amsb <= in_a[WIDTH-1];
            s0_bmsb <= b_eff[WIDTH-1];
        end
    end

    // ---------------- prefix network ----------------
    // Bit k of lv_go/lv_po describes the group of bits [k..0] that is
    // resolved so far. Levels 0-1 read S0 and levels 2-3 read S1.
    logic [LEVELS-1:0][WIDTH-1:0] lv_gi, lv_pi, lv_go, lv_po;
    logic [WIDTH-1:0] s1_grp_g, s1_grp_p, s1_bit_p;
    logic             s1_cin, s1_amsb, s1_bmsb;

    assign lv_gi[0] = s0_g;
    assign lv_pi[0] = s0_p;
    assign lv_gi[1] = lv_go[0];
    assign lv_pi[1] = lv_po[0];
    assign lv_gi[2] = s1_grp_g;
    assign lv_pi[2] = s1_grp_p;
    assign lv_gi[3] = lv_go[2];
    assign lv_pi[3] = lv_po[2];

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar k = 0; k < WIDTH; k++) begin : g_bit
            if (k >= (1 << l)) begin : g_comb
                assign lv_go[l][k] = lv_gi[l][k] | (lv_gi[l][k-(1<<l)] & lv_pi[l][k]);
                assign lv_po[l][k] = lv_pi[l][k] & lv_pi[l][k-(1<<l)];
            end else begin : g_pass
                // Bit k is already fully resolved, or the span exceeds WIDTH.
                assign lv_go[l][k] = lv_gi[l][k];
                assign lv_po[l][k] = lv_pi[l][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_grp_g <= lv_go[1];
            s1_grp_p <= lv_po[1];
            s1_bit_p <= s0_p;
            s1_cin   <= s0_cin;
            s1_amsb  <= s0_amsb;
            s1_bmsb  <= s0_bmsb;
        end
    end

    // ---------------- carries, sum, overflow ----------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_wrap, sum_final;
    logic             ovf_c;

    always_comb begin
        carry[0] = s1_cin;
        for (int k = 0; k < WIDTH; k++)
            carry[k+1] = lv_go[3][k] | (lv_po[3][k] & s1_cin);
    end

    assign sum_wrap = s1_bit_p ^ carry[WIDTH-1:0];
    assign ovf_c    = (s1_amsb == s1_bmsb) & (sum_wrap[WIDTH-1] != s1_amsb);

`ifdef PREFIX_ADDSUB_SATURATE_EN
    // Clamp toward the sign of A: the most negative value or the most positive value.
    assign sum_final = !ovf_c   ? sum_wrap :
                       s1_amsb  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum_final = sum_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (advance) begin
            out_sum  <= sum_final;
            out_cout <= carry[WIDTH];
            out_ovf  <= ovf_c;
        end
    end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench for prefix_addsub_pipe (WIDTH=12). An arithmetic
// reference model produces the expected value for every accepted token. Some
// directed vectors also carry hand-computed literals that pin the model.
module tb_prefix_addsub_pipe;
    localparam int W = 12;

    logic         clk, rst;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] out_sum;

    prefix_addsub_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PREFIX_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        int ua, ub, sa, sb, ci, ur, sr;
        ua = int'(a);
        ub = int'(b);
        ci = cin ? 1 : 0;
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (sub) begin
            ur = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ur >= 0);
        end else begin
            ur = ua + ub + ci;
            sr = sa + sb + ci;
            co = (ur >= (1 << W));
        end
        s  = ur[W-1:0];
        ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        if (SAT && ov)
            s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    typedef struct {
        logic [W-1:0] sum;
        logic         cout, ovf;
        bit           has_lit;
        logic [W-1:0] lsum;
        logic         lcout, lovf;
    } exp_t;
    exp_t q[$];

    bit           cur_lit;
    logic [W-1:0] cur_lsum;
    logic         cur_lcout, cur_lovf;

    // Compare process: pops on every output transfer, pushes on every input
    // transfer, and checks hold behaviour while the output is stalled.
    bit           stalled_prev = 0;
    logic [W-1:0] h_sum;
    logic         h_cout, h_ovf;

    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 0;
        end else begin
            if (stalled_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, h_sum);
                chk("hold_cout", out_cout, h_cout);
                chk("hold_ovf", out_ovf, h_ovf);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                stalled_prev = 1;
                h_sum = out_sum; h_cout = out_cout; h_ovf = out_ovf;
            end else begin
                stalled_prev = 0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum", out_sum, e.sum);
                    chk("cout", out_cout, e.cout);
                    chk("ovf", out_ovf, e.ovf);
                    if (e.has_lit) begin
                        chk("lit_sum", out_sum, e.lsum);
                        chk("lit_cout", out_cout, e.lcout);
                        chk("lit_ovf", out_ovf, e.lovf);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                model(in_a, in_b, in_cin, in_sub, e.sum, e.cout, e.ovf);
                e.has_lit = cur_lit;
                e.lsum = cur_lsum; e.lcout = cur_lcout; e.lovf = cur_lovf;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit lit, input logic [W-1:0] ls,
                        input logic lc, input logic lo);
        int t;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        cur_lit = lit; cur_lsum = ls; cur_lcout = lc; cur_lovf = lo;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cur_lit = 0;
    endtask

    task automatic latency3();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("latency", n, 3);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        cur_lit = 0; cur_lsum = '0; cur_lcout = 0; cur_lovf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with literal expectations.
        send(12'hFFF, 12'h001, 0, 0, 1, 12'h000, 1, 0);
        latency3();
        drain();
        send(12'h7FF, 12'h001, 0, 0, 1, SAT ? 12'h7FF : 12'h800, 0, 1);
        send(12'h005, 12'h007, 0, 1, 1, 12'hFFE, 0, 0);
        send(12'h800, 12'h001, 0, 1, 1, SAT ? 12'h800 : 12'h7FF, 1, 1);
        send(12'h555, 12'hAAA, 1, 0, 1, 12'h000, 1, 0);
        send(12'h010, 12'h00F, 1, 1, 1, 12'h000, 1, 0);
        drain();

        // Mixed modes back to back, and a bubble carrying garbage operands.
        send(12'h123, 12'h456, 0, 0, 1, 12'h579, 0, 0);
        send(12'h123, 12'h456, 0, 1, 1, 12'hCCD, 0, 0);
        in_a = 12'hABC; in_b = 12'hDEF; in_sub = 1'b1; in_cin = 1'b1;
        @(posedge clk);
        #1;
        send(12'h000, 12'h001, 1, 1, 1, 12'hFFE, 0, 0);
        send(12'h800, 12'h800, 0, 0, 1, SAT ? 12'h800 : 12'h000, 1, 1);
        send(12'h3A5, 12'h0C3, 1, 0, 0, '0, 0, 0);
        send(12'h9F0, 12'h7F0, 0, 1, 0, '0, 0, 0);
        drain();

        // Backpressure: 5 back-to-back tokens and a 2-cycle output stall.
        fork
            begin
                for (int k = 1; k <= 5; k++)
                    send(W'(k), W'(k), 0, 0, 1, W'(2*k), 0, 0);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!out_valid && t < 20);
                if (!out_valid) fail_now("bp_first_valid");
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_no_gap", out_valid, 1);
                end
            end
        join
        drain();

        // Reset while 3 tokens are in flight and the output is stalled.
        out_ready = 1'b0;
        send(12'h100, 12'h011, 0, 0, 0, '0, 0, 0);
        send(12'h222, 12'h333, 1, 0, 0, '0, 0, 0);
        send(12'h7F0, 12'h020, 0, 0, 0, '0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_during_rst", in_ready, 1);
        @(posedge clk);
        #1;
        q.delete();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_sum", out_sum, 0);
        chk("post_rst_cout", out_cout, 0);
        chk("post_rst_ovf", out_ovf, 0);
        chk("post_rst_in_ready", in_ready, 1);
        rst = 1'b0;
        out_ready = 1'b1;
        send(12'h0F0, 12'h00F, 1, 0, 1, 12'h100, 0, 0);
        latency3();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
